// File: rtl/bus_access_ctrl.sv
// Round-robin two-master bus access controller; ack lands WS+2 cycles after the request is seen.
// Chip enable holds until rdy after the wait count; optional rdy watchdog under BUS_TIMEOUT_EN.
module bus_access_ctrl #(
  parameter int unsigned WS_CE0         = 2,
  parameter int unsigned WS_CE1         = 4,
  parameter int unsigned WS_CS          = 1,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [31:0] addr0,
  input  logic        req1,
  input  logic [31:0] addr1,
  input  logic        rdy,
  output logic [1:0]  gnt,
  output logic [1:0]  ack,
  output logic        err,
  output logic [31:0] bus_addr,
  output logic        ce0,
  output logic        ce1,
  output logic        cs,
  output logic        busy
);

  if (WS_CE0 > 15 || WS_CE1 > 15 || WS_CS > 15 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_params
    $error("bus_access_ctrl: parameter out of range");
  end

  localparam logic [3:0] WS_CE0_L = 4'(WS_CE0);
  localparam logic [3:0] WS_CE1_L = 4'(WS_CE1);
  localparam logic [3:0] WS_CS_L  = 4'(WS_CS);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ptr_q, ptr_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic        ce0_q, ce0_d;
  logic        ce1_q, ce1_d;
  logic        cs_q, cs_d;
  logic        busy_q, busy_d;
  logic        win1;
  logic [31:0] sel_addr;

`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] to_cnt_q, to_cnt_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    ack_d    = ack_q;
    err_d    = err_q;
    addr_d   = addr_q;
    ce0_d    = ce0_q;
    ce1_d    = ce1_q;
    cs_d     = cs_q;
`ifdef BUS_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
`endif
    // Requester 1 wins when alone, or on a tie when the pointer favours it.
    win1     = req1 && (!req0 || ptr_q);
    sel_addr = win1 ? addr1 : addr0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = ACCESS;
          gnt_d   = win1 ? 2'b10 : 2'b01;
          addr_d  = sel_addr;
          cnt_d   = 4'd0;
`ifdef BUS_TIMEOUT_EN
          to_cnt_d = 8'd0;
`endif
          // Explicit equality so an unknown upper address selects no target.
          if (sel_addr[31:30] == 2'b10) begin
            ce0_d = 1'b1;
            cnt_d = WS_CE0_L;
          end else if (sel_addr[31:30] == 2'b11) begin
            ce1_d = 1'b1;
            cnt_d = WS_CE1_L;
          end else if (sel_addr[31] == 1'b0) begin
            cs_d  = 1'b1;
            cnt_d = WS_CS_L;
          end
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (rdy) begin
          state_d = DONE;
          ack_d   = gnt_q;
          ce0_d   = 1'b0;
          ce1_d   = 1'b0;
          cs_d    = 1'b0;
        end else begin
`ifdef BUS_TIMEOUT_EN
          to_cnt_d = to_cnt_q + 8'd1;
          if (to_cnt_d == TO_LIMIT) begin
            state_d = DONE;
            ack_d   = gnt_q;
            err_d   = 1'b1;
            ce0_d   = 1'b0;
            ce1_d   = 1'b0;
            cs_d    = 1'b0;
          end
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        ack_d   = 2'b00;
        err_d   = 1'b0;
        ptr_d   = gnt_q[0];
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        ack_d   = 2'b00;
        err_d   = 1'b0;
        ce0_d   = 1'b0;
        ce1_d   = 1'b0;
        cs_d    = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      ptr_q    <= 1'b0;
      gnt_q    <= 2'b00;
      ack_q    <= 2'b00;
      err_q    <= 1'b0;
      addr_q   <= 32'd0;
      ce0_q    <= 1'b0;
      ce1_q    <= 1'b0;
      cs_q     <= 1'b0;
      busy_q   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      to_cnt_q <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      ce0_q    <= ce0_d;
      ce1_q    <= ce1_d;
      cs_q     <= cs_d;
      busy_q   <= busy_d;
`ifdef BUS_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
`endif
    end
  end

  assign gnt      = gnt_q;
  assign ack      = ack_q;
  assign err      = err_q;
  assign bus_addr = addr_q;
  assign ce0      = ce0_q;
  assign ce1      = ce1_q;
  assign cs       = cs_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_bus_access_ctrl.sv
// Directed bench for bus_access_ctrl; timeout expectations follow BUS_TIMEOUT_EN.
module tb_bus_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, rdy;
  logic [31:0] addr0, addr1;
  logic [1:0]  gnt, ack;
  logic        err, ce0, ce1, cs, busy;
  logic [31:0] bus_addr;

  int checks   = 0;
  int failures = 0;

  bus_access_ctrl dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
    .rdy(rdy),
    .gnt(gnt), .ack(ack), .err(err), .bus_addr(bus_addr),
    .ce0(ce0), .ce1(ce1), .cs(cs), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packed view: {gnt[1:0], ack[1:0], err, ce0, ce1, cs, busy}
  function automatic logic [31:0] pk(input logic [1:0] g, input logic [1:0] a, input logic e,
                                     input logic c0, input logic c1, input logic c, input logic b);
    return {23'd0, g, a, e, c0, c1, c, b};
  endfunction

  task automatic chk_outs(input string tag, input logic [31:0] exp);
    chk(tag, pk(gnt, ack, err, ce0, ce1, cs, busy), exp);
  endtask

  initial begin
    logic [1:0] eg, ea;
    logic       e0, e1, ec, eb;
    int         p;

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; rdy = 1'b0;
    addr0 = 32'd0; addr1 = 32'd0;

    // Reset then idle
    step();
    step();
    chk_outs("reset_outs", 32'd0);
    chk("reset_addr", bus_addr, 32'd0);
    rst = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step();
      chk_outs($sformatf("idle_c%0d", c), 32'd0);
    end
    chk("idle_addr", bus_addr, 32'd0);

    // Single ce1 access from requester 0; address change after grant is ignored
    req0 = 1'b1; addr0 = 32'hC000_0010; rdy = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      eg = (c <= 6) ? 2'b01 : 2'b00;
      ea = (c == 6) ? 2'b01 : 2'b00;
      e1 = (c <= 5);
      eb = (c <= 6);
      chk_outs($sformatf("ce1_c%0d", c), pk(eg, ea, 1'b0, 1'b0, e1, 1'b0, eb));
      if (c <= 6) chk($sformatf("ce1_addr_c%0d", c), bus_addr, 32'hC000_0010);
      if (c == 3) addr0 = 32'h0000_0000;
      if (c == 6) req0 = 1'b0;
    end

    // Fresh pointer for the contention run
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Round-robin contention: 9-cycle period, ce0 access then cs access
    req0 = 1'b1; addr0 = 32'h8000_0000;
    req1 = 1'b1; addr1 = 32'h0000_0004;
    rdy  = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      step();
      p  = (c - 1) % 9;
      eg = (p <= 3) ? 2'b01 : ((p >= 5 && p <= 7) ? 2'b10 : 2'b00);
      ea = (p == 3) ? 2'b01 : ((p == 7) ? 2'b10 : 2'b00);
      e0 = (p <= 2);
      ec = (p == 5 || p == 6);
      eb = (p != 4 && p != 8);
      chk_outs($sformatf("rr_c%0d", c), pk(eg, ea, 1'b0, e0, 1'b0, ec, eb));
      if (p <= 3) chk($sformatf("rr_addr_c%0d", c), bus_addr, 32'h8000_0000);
      if (p >= 5 && p <= 7) chk($sformatf("rr_addr_c%0d", c), bus_addr, 32'h0000_0004);
    end
    req0 = 1'b0; req1 = 1'b0;

    // rdy stall on a cs access: rdy low cycles 2..6, high from cycle 7
    req1 = 1'b1; addr1 = 32'h4000_0100; rdy = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      step();
      eg = (c <= 8) ? 2'b10 : 2'b00;
      ea = (c == 8) ? 2'b10 : 2'b00;
      ec = (c <= 7);
      eb = (c <= 8);
      chk_outs($sformatf("stall_c%0d", c), pk(eg, ea, 1'b0, 1'b0, 1'b0, ec, eb));
      if (c == 7) rdy = 1'b1;
      if (c == 8) req1 = 1'b0;
    end

    // Reset mid-access of a ce1 access
    req0 = 1'b1; addr0 = 32'hC000_0000; rdy = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c <= 2) chk_outs($sformatf("rmid_c%0d", c), pk(2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
      else        chk_outs($sformatf("rmid_c%0d", c), 32'd0);
      if (c == 2) begin rst = 1'b1; req0 = 1'b0; end
      if (c == 3) rst = 1'b0;
    end

    // Requester 1 alone after reset; dropping req1 after grant does not cancel the access
    req1 = 1'b1; addr1 = 32'hC000_0020;
    for (int c = 1; c <= 7; c++) begin
      step();
      eg = (c <= 6) ? 2'b10 : 2'b00;
      ea = (c == 6) ? 2'b10 : 2'b00;
      e1 = (c <= 5);
      eb = (c <= 6);
      chk_outs($sformatf("post_rst_c%0d", c), pk(eg, ea, 1'b0, 1'b0, e1, 1'b0, eb));
      if (c == 1) chk("post_rst_addr", bus_addr, 32'hC000_0020);
      if (c == 2) req1 = 1'b0;
    end

    // ce0 access with rdy stuck low
    req0 = 1'b1; addr0 = 32'h8000_0040; rdy = 1'b0;
`ifdef BUS_TIMEOUT_EN
    for (int c = 1; c <= 20; c++) begin
      step();
      eg = (c <= 19) ? 2'b01 : 2'b00;
      ea = (c == 19) ? 2'b01 : 2'b00;
      e0 = (c <= 18);
      eb = (c <= 19);
      chk_outs($sformatf("timeout_c%0d", c), pk(eg, ea, (c == 19), e0, 1'b0, 1'b0, eb));
      if (c == 19) req0 = 1'b0;
    end
`else
    for (int c = 1; c <= 100; c++) begin
      step();
      chk_outs($sformatf("hold_c%0d", c), pk(2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_access_ctrl.md
Name: bus_access_ctrl

Overview:
Two-requester bus access controller for the upper-address-decoded target space: ce0 (addr[31:30]=2'b10), ce1 (2'b11) and cs (2'b0?).
- Arbitrates round-robin between requesters and latches the winner's address.
- Asserts exactly one one-hot chip enable for a per-target wait-state count, then waits for target ready.
- Returns a single-cycle ack to the winner.
- Sits between the two bus masters and the decoded target chip enables.

Parameters:
WS_CE0, 2, wait cycles before rdy is sampled for ce0 target (0..15)
WS_CE1, 4, wait cycles before rdy is sampled for ce1 target (0..15)
WS_CS, 1, wait cycles before rdy is sampled for cs target (0..15)
TIMEOUT_CYCLES, 16, rdy-low cycles before abort (BUS_TIMEOUT_EN only; 1..255)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
req0  input  1  requester 0 access request, held until ack0
addr0  input  32  requester 0 address, stable while req0 high
req1  input  1  requester 1 access request, held until ack1
addr1  input  32  requester 1 address, stable while req1 high
rdy  input  1  target ready, shared by all targets
gnt  output  2  one-hot grant (bit0 = requester 0), registered
ack  output  2  one-hot single-cycle completion strobe, registered
err  output  1  access aborted, valid with ack
bus_addr  output  32  latched address of granted access, registered
ce0  output  1  target 0 chip enable, registered
ce1  output  1  target 1 chip enable, registered
cs  output  1  target 2 chip select, registered
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values (rst high at clk edge):
  - state=IDLE; gnt=0, ack=0, err=0, bus_addr=0, ce0=ce1=cs=0, busy=0.
  - Round-robin pointer=0, so requester 0 wins the first tie.
  - Reset mid-access aborts immediately; no ack is issued.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - No req: stay in IDLE.
  - Only one req high: that requester wins.
  - Both high: winner is the requester not granted last (pointer).
  - At the edge: gnt<=winner, bus_addr<=winner addr.
  - Decode addr[31:30] (10->ce0, 11->ce1, 0?->cs): set that enable, load wait counter with the matching WS_*, go to ACCESS.
- ACCESS:
  - Exactly one of ce0/ce1/cs is high; gnt and bus_addr are held.
  - Counter>0: decrement; rdy is ignored.
  - Counter==0 and rdy=1: go to DONE, drop chip enable, ack<=gnt.
  - Counter==0 and rdy=0: stay in ACCESS.
- DONE (exactly one cycle):
  - ack one-hot high; gnt still high.
  - Next edge: gnt<=0, ack<=0, pointer<=other requester, go to IDLE.
- Timing:
  - Req first seen in IDLE at cycle 0 -> chip enable cycles 1..WS+1 (rdy high) -> ack at cycle WS+2.
  - A new grant is possible at cycle WS+3, so there is one idle cycle between accesses.
- Requester behaviour during an access:
  - req deasserting after grant is ignored; the access completes.
  - addrN changes after grant are ignored (address is latched).
- Counter width is 4 bits; WS=0 means rdy is sampled in the first ACCESS cycle.
- ce0, ce1 and cs are never simultaneously high; all are 0 outside ACCESS.
- X on addr[31] must not assert any chip enable.
  - Decode uses explicit equality; an unknown address maps to no target.
  - The access then completes via rdy with all enables low.
- busy = (state != IDLE), registered alongside state.

Optional Feature:
BUS_TIMEOUT_EN
- Defined:
  - An 8-bit timeout counter counts ACCESS cycles with wait counter==0 and rdy=0.
  - On reaching TIMEOUT_CYCLES, go to DONE with err=1 alongside ack; chip enable drops.
  - The counter clears on entry to ACCESS.
- Not defined: no timeout counter; ACCESS waits indefinitely for rdy; err is tied 0.

Test Plan:
- Reset then idle: rst high 2 cycles, no req -> all outputs 0, busy=0 for 10 cycles.
- Single access, ce1 target: req0=1, addr0=32'hC000_0010, rdy=1.
  - gnt=2'b01 and bus_addr=C000_0010 at cycle 1.
  - ce1 high cycles 1..5.
  - ack=2'b01 at cycle 6; ce0=cs=0 throughout.
- Round-robin contention: req0 and req1 high continuously, addr0=32'h8000_0000, addr1=32'h0000_0004, rdy=1.
  - Grants alternate 01,10,01,10.
  - ce0 window is 3 cycles; cs window is 2 cycles.
  - Ack at cycles 4 then 8.
- rdy stall: cs access with rdy=0 for 5 cycles after wait count expires -> cs stays high those 5 cycles, then ack 1 cycle after rdy rises.
- Reset mid-access: rst at cycle 2 of a ce1 access -> next cycle ce1=0, gnt=0, no ack; a subsequent req1-only request is granted to requester 1.
- Timeout (BUS_TIMEOUT_EN): ce0 access with rdy stuck 0 -> after 2 wait cycles plus 16 rdy-low cycles, ack=2'b01 with err=1; without the macro, ce0 is held and no ack appears for 100 cycles.
